uart_tx_fifo: RTL

//   Parametrised UART transmitter with an internal byte FIFO, configurable frame format and

---
 rtl/uart_tx_fifo_pkg.sv | 23 ++
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the buffered UART transmitter.
package uart_tx_fifo_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } tx_state_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port and serial-line status of the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 wr_dv;
  logic [DATA_BITS-1:0] wr_byte;
  logic                 full;
  logic                 empty;
  logic [LEVEL_W-1:0]   level;
  logic                 overflow;
  logic                 tx_serial;
  logic                 tx_active;
  logic                 tx_done;

  modport master (
    output wr_dv, wr_byte,
    input  full, empty, level, overflow, tx_serial, tx_active, tx_done
  );

  modport slave (
    input  wr_dv, wr_byte,
    output full, empty, level, overflow, tx_serial, tx_active, tx_done
  );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered storage, explicit occupancy and drop-on-full flag.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame FSM with optional parity and inter-frame gap.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned INTER_GAP    = 0
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(max3(DATA_BITS, STOP_BITS, INTER_GAP) + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((INTER_GAP == 0) ? 0 : INTER_GAP - 1);

  tx_state_t            state, state_nxt;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 parity_bit;
  logic                 bit_end;
  logic                 pop;
  logic                 line_nxt;
  logic                 done_nxt;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (bus.wr_dv),
    .pop      (pop),
    .din      (bus.wr_byte),
    .dout     (fifo_dout),
    .full     (bus.full),
    .empty    (bus.empty),
    .level    (bus.level),
    .overflow (bus.overflow)
  );

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    line_nxt  = 1'b1;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.empty) begin
          pop       = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        line_nxt = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        line_nxt = shift_reg[0];
        if (bit_end && bit_cnt == DATA_LAST)
          state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        line_nxt = parity_bit;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end && bit_cnt == STOP_LAST) begin
          done_nxt = 1'b1;
          if (INTER_GAP != 0) begin
            state_nxt = ST_GAP;
          end else if (!bus.empty) begin
            pop       = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (bit_end && bit_cnt == GAP_LAST) begin
          if (!bus.empty) begin
            pop       = 1'b1;
            state_nxt = ST_START;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      bus.tx_serial <= 1'b1;
      bus.tx_active <= 1'b0;
      bus.tx_done   <= 1'b0;
    end else begin
      baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : baud_cnt + CW'(1);
      if (state_nxt != state) bit_cnt <= '0;
      else if (bit_end)       bit_cnt <= bit_cnt + BW'(1);
      if (pop) begin
        shift_reg  <= fifo_dout;
        parity_bit <= (PARITY == PARITY_ODD) ? ~^fifo_dout : ^fifo_dout;
      end else if (state == ST_DATA && bit_end) begin
        shift_reg <= shift_reg >> 1;
      end
      bus.tx_serial <= line_nxt;
      bus.tx_active <= (state != ST_IDLE);
      bus.tx_done   <= done_nxt;
    end
  end

endmodule
